mem_port_arbiter: RTL

Shares the single main-memory port between the instruction-cache miss path and the data-cache controller (read fills and write-through stores). It grants one requester at a time and drives the multi-cycle memory handshake on its behalf. It returns read data or write completion with a one-cycle done pulse, and aborts any memory access that exceeds a bounded wait. It sits between the two cache controllers and the main-memory model.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one main-memory port between I-cache and D-cache with bounded wait
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is D-cache-first fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              own_dc, own_dc_nxt;
    logic              we, we_nxt;
    logic [7:0]        wait_cnt, wait_cnt_nxt;
    logic              mem_rd_nxt, mem_wr_nxt;
    logic              ic_done_nxt, dc_done_nxt, err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, rdata_nxt;
    logic              any_req, grant_dc, timed_out;

    assign any_req   = ic_req | dc_req;
    assign timed_out = (wait_cnt == LAST_WAIT);

`ifdef ARB_ROUND_ROBIN_EN
    // last_dc = 1 when the D-cache won the most recent grant
    logic last_dc;

    assign grant_dc = dc_req & (~ic_req | ~last_dc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dc <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_dc <= grant_dc;
        end
    end
`else
    assign grant_dc = dc_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (mem_ready || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Computes the next value of every registered output and datapath register
    always_comb begin
        own_dc_nxt    = own_dc;
        we_nxt        = we;
        wait_cnt_nxt  = wait_cnt;
        mem_rd_nxt    = mem_rd;
        mem_wr_nxt    = mem_wr;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        ic_done_nxt   = 1'b0;
        dc_done_nxt   = 1'b0;
        err_nxt       = err;
        rdata_nxt     = rdata;
        case (state)
            IDLE: begin
                if (any_req) begin
                    own_dc_nxt    = grant_dc;
                    we_nxt        = grant_dc & dc_we;
                    mem_addr_nxt  = grant_dc ? dc_addr : ic_addr;
                    mem_wdata_nxt = grant_dc ? dc_wdata : '0;
                    mem_rd_nxt    = ~(grant_dc & dc_we);
                    mem_wr_nxt    = grant_dc & dc_we;
                    wait_cnt_nxt  = 8'd0;
                end
            end
            BUSY: begin
                if (mem_ready || timed_out) begin
                    mem_rd_nxt  = 1'b0;
                    mem_wr_nxt  = 1'b0;
                    ic_done_nxt = ~own_dc;
                    dc_done_nxt = own_dc;
                    // mem_ready wins a tie with the timeout
                    err_nxt     = ~mem_ready;
                    rdata_nxt   = (mem_ready && !we) ? mem_rdata : '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            RESP: begin
                err_nxt   = 1'b0;
                rdata_nxt = '0;
            end
            default: begin
                mem_rd_nxt = 1'b0;
                mem_wr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_dc    <= 1'b0;
            we        <= 1'b0;
            wait_cnt  <= 8'd0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            own_dc    <= own_dc_nxt;
            we        <= we_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            ic_done   <= ic_done_nxt;
            dc_done   <= dc_done_nxt;
            err       <= err_nxt;
            rdata     <= rdata_nxt;
        end
    end
endmodule
